adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares one DATA_W-bit adder among NUM_REQ requesters.
//  Each requester offers an operand pair on a valid/ready handshake. The block grants one pair,
//  registers the sum and carry, and returns them with the requester's ID on a valid/ready response port.
//  It sits between the operand sources (ui_in nibble pairs, later other masters) and the shared adder.
// PARAMETERS
//  NUM_REQ  4  number of requesters, >=2
//  DATA_W   4  operand width; sum is DATA_W+1 bits (carry in MSB)
//  ID_W     $clog2(NUM_REQ)  localparam, width of requester ID
// PORTS
//  clk        in   1               clock, all state on rising edge
//  rst        in   1               synchronous, active-high reset
//  req_valid  in   NUM_REQ         per-requester operand valid
//  req_ready  out  NUM_REQ         per-requester accept strobe; one-hot or zero
//  req_a      in   NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
//  req_b      in   NUM_REQ*DATA_W  operand B, same packing
//  resp_valid out  1               registered result valid
//  resp_ready in   1               downstream accepts result
//  resp_sum   out  DATA_W+1        registered a+b, zero-extended, carry at [DATA_W]
//  resp_id    out  ID_W            index of the requester that produced resp_sum
//  busy       out  1               resp_valid held, awaiting resp_ready
// BEHAVIOUR
//  Reset (rst=1 at edge): resp_valid=0, resp_sum=0, resp_id=0, busy=0, last_grant=NUM_REQ-1.
//   req_ready is 0 while rst=1. Reset mid-transaction drops the pending result; no response is emitted.
//  FSM: EMPTY (no result held) and FULL (resp_valid=1). busy==FULL.
//  can_accept = EMPTY | (FULL & resp_ready). Throughput is 1 result/cycle.
//  Grant is combinational. When can_accept and |req_valid, g = first i with req_valid[i],
//   scanning last_grant+1, +2, ... modulo NUM_REQ. req_ready[g]=1 and all others are 0.
//   req_ready never asserts for a requester whose valid is 0.
//  Accept (req_valid[g] & req_ready[g]) at edge N:
//   resp_sum <= {1'b0,a_g}+{1'b0,b_g}, resp_id <= g, last_grant <= g, state <= FULL.
//   resp_valid=1 in cycle N+1, so latency is exactly 1 cycle.
//  FULL & resp_ready & no accept: state <= EMPTY. resp_sum/resp_id hold their last values.
//  FULL & !resp_ready: resp_valid, resp_sum and resp_id are stable. No grant and all req_ready=0.
//  Simultaneous resp handshake and new accept: the response is retired and the new result loads on the same edge.
//   resp_valid stays 1.
//  last_grant changes only on accept, so idle cycles do not rotate priority.
//  Fairness: a requester holding valid waits at most NUM_REQ-1 grants.
//  Arithmetic is unsigned with no saturation. Max sum is 2*(2^DATA_W-1), e.g. 15+15=30=5'b11110.
//  Requesters may drop valid without a handshake. Operands are sampled only on the accept edge.
// STRUCTURE
//  Package adder_share_pkg holds state enum {ST_EMPTY, ST_FULL} and the DATA_W/NUM_REQ defaults.
//  Sub-module rr_pick (req, last -> one-hot grant, index) is purely combinational and reusable.
//  Top holds the operand mux, the registered adder, the FSM and last_grant.
// TESTING
//  1. Reset: rst=1 for 2 cycles with all valid=1 -> req_ready=0, resp_valid=0, resp_sum=0.
//     After release, req0 is granted first.
//  2. Single requester: req2 a=7 b=9, resp_ready=1 -> req_ready=4'b0100 at N.
//     At N+1 resp_valid=1, resp_sum=16, resp_id=2.
//  3. All four valid, resp_ready=1 -> grant order 0,1,2,3,0, one result per cycle.
//     a=15 b=15 gives resp_sum=30.
//  4. Backpressure: resp_ready=0 for 5 cycles while FULL -> all req_ready=0, outputs stable.
//     When resp_ready rises, the next grant happens in that same cycle.
//  5. Priority hold: grant req1, idle 3 cycles, then req0 and req1 valid -> req0 is not skipped.
//     Order is 2,3,0 scan, so req0 is granted before req1.
//  6. Reset mid-operation: rst while FULL and resp_ready=0 -> resp_valid=0 next cycle.
//     The pending result is never presented.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared types and default sizing for the adder-sharing arbiter slice.
package adder_share_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_DATA_W  = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage : adder_share_pkg

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between operand sources and the shared-adder arbiter.
interface adder_share_arbiter_if
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = DEFAULT_DATA_W
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_W:0]           resp_sum;
  logic [ID_W-1:0]           resp_id;
  logic                      busy;

  // Requesters and the result consumer sit on the master side.
  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_id, busy
  );

endinterface : adder_share_arbiter_if

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    // NOTE: every output gets a default before the scan so no path leaves a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int pos;
      pos = (int'(last) + k) % N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule : rr_pick

// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one registered adder among NUM_REQ requesters.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_share_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q;
  logic [DATA_W:0]     sum_q;
  logic [ID_W-1:0]     id_q;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic                can_accept;
  logic                accept;
  logic [DATA_W-1:0]   a_sel, b_sel;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req   (bus.req_valid),
    .last  (last_grant_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A held result blocks new grants unless it retires on this same edge.
  assign can_accept    = (state_q == ST_EMPTY) || bus.resp_ready;
  assign accept        = !rst && can_accept && pick_any;
  assign bus.req_ready = accept ? pick_grant : '0;

  assign a_sel = bus.req_a[int'(pick_idx)*DATA_W +: DATA_W];
  assign b_sel = bus.req_b[int'(pick_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)               state_d = ST_FULL;
        else if (bus.resp_ready)  state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Result and priority pointer only move on an accepted grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q        <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      sum_q        <= {1'b0, a_sel} + {1'b0, b_sel};
      id_q         <= pick_idx;
      last_grant_q <= pick_idx;
    end
  end

  assign bus.resp_valid = (state_q == ST_FULL);
  assign bus.busy       = (state_q == ST_FULL);
  assign bus.resp_sum   = sum_q;
  assign bus.resp_id    = id_q;

endmodule : adder_share_arbiter

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios then random traffic against a behavioural model.
module tb_adder_share_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  adder_share_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: one held result slot plus the last granted index.
  bit m_full;
  int m_sum, m_id, m_last;
  bit m_acc;
  int m_g, m_a, m_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_sum  = 0;
    m_id   = 0;
    m_last = N - 1;
  endtask

  task automatic model_eval();
    logic [N-1:0] exp_ready;
    exp_ready = '0;
    m_acc = 1'b0;
    m_g   = 0;
    if (!rst && (!m_full || bus.resp_ready === 1'b1)) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (!m_acc && bus.req_valid[i] === 1'b1) begin
          m_acc = 1'b1;
          m_g   = i;
          exp_ready[i] = 1'b1;
        end
      end
    end
    m_a = int'(bus.req_a >> (m_g * W)) % (1 << W);
    m_b = int'(bus.req_b >> (m_g * W)) % (1 << W);
    check("req_ready",  32'(bus.req_ready),  32'(exp_ready));
    check("resp_valid", 32'(bus.resp_valid), 32'(m_full));
    check("busy",       32'(bus.busy),       32'(m_full));
    check("resp_sum",   32'(bus.resp_sum),   32'(m_sum));
    check("resp_id",    32'(bus.resp_id),    32'(m_id));
  endtask

  task automatic model_update();
    if (rst) model_reset();
    else if (m_acc) begin
      m_sum  = m_a + m_b;
      m_id   = m_g;
      m_last = m_g;
      m_full = 1'b1;
    end else if (m_full && bus.resp_ready === 1'b1) m_full = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] a,
                       input logic [N*W-1:0] b, input logic rr);
    bus.req_valid  = v;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.resp_ready = rr;
  endtask

  initial begin
    logic [W:0]   held_sum;
    logic [1:0]   held_id;
    int           exp_order [5] = '{0, 1, 2, 3, 0};
    model_reset();

    // Reset with every requester valid: nothing may be granted.
    rst = 1'b1;
    drive(4'b1111, 16'h1234, 16'h4321, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t1_first_id",    32'(bus.resp_id),    32'd0);
    check("t1_first_valid", 32'(bus.resp_valid), 32'd1);

    // Single requester 2: 7 + 9.
    drive(4'b0100, 16'h0700, 16'h0900, 1'b1);
    tick();
    check("t2_sum", 32'(bus.resp_sum), 32'd16);
    check("t2_id",  32'(bus.resp_id),  32'd2);

    // Park the pointer on requester 3, then all four contend with 15+15.
    drive(4'b1000, 16'h1000, 16'h2000, 1'b1);
    tick();
    drive(4'b1111, 16'hFFFF, 16'hFFFF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_id",    32'(bus.resp_id),    32'(exp_order[k]));
      check("t3_sum",   32'(bus.resp_sum),   32'd30);
      check("t3_valid", 32'(bus.resp_valid), 32'd1);
    end

    // Backpressure: result must hold for five cycles.
    held_sum = bus.resp_sum;
    held_id  = bus.resp_id;
    for (int k = 0; k < 5; k++) begin
      drive(4'($urandom_range(15, 1)), 16'($urandom), 16'($urandom), 1'b0);
      tick();
      check("t4_hold_sum", 32'(bus.resp_sum), 32'(held_sum));
      check("t4_hold_id",  32'(bus.resp_id),  32'(held_id));
    end
    drive(4'b1111, 16'h5555, 16'h3333, 1'b1);
    #1;
    check("t4_regrant", 32'(|bus.req_ready), 32'd1);
    tick();

    // Idle cycles must not rotate priority after granting requester 1.
    drive(4'b0010, 16'h0030, 16'h0040, 1'b1);
    tick();
    check("t5_id1", 32'(bus.resp_id), 32'd1);
    drive(4'b0000, 16'h0000, 16'h0000, 1'b1);
    repeat (3) tick();
    drive(4'b0011, 16'h0021, 16'h0012, 1'b1);
    #1;
    check("t5_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    check("t5_id0", 32'(bus.resp_id), 32'd0);

    // Reset while a result is held and stalled.
    drive(4'b0000, 16'h0000, 16'h0000, 1'b0);
    tick();
    check("t6_held", 32'(bus.resp_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("t6_dropped", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;
    drive(4'b0000, 16'h0000, 16'h0000, 1'b1);
    repeat (2) tick();
    check("t6_quiet", 32'(bus.resp_valid), 32'd0);

    // Random traffic, including occasional resets and stalls.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(49) == 0);
      drive(4'($urandom), 16'($urandom), 16'($urandom), $urandom_range(3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_adder_share_arbiter
